// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a write FIFO, status/level readback,
// sticky overflow flag and a drained interrupt.
module uart_tx_fifo #(
    parameter int unsigned CLOCK_FREQ = 62500000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq,
    output logic        tx
);

    localparam int unsigned DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    BAUD_LAST = CW'(DIV - 1);
    localparam logic [FIFO_AW:0] FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_baud;
    logic [CW-1:0]      w_baud_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic [2:0]         r_bitpos;
    logic [2:0]         w_bitpos_nxt;
    logic [2:0]         w_bitpos_inc;
    logic [7:0]         r_shift;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic               r_irq_en;
    logic               r_irq;

    logic               w_empty;
    logic               w_full;
    logic               w_done;
    logic               w_bit_end;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_ctrl_wr;
    logic               w_flush;
    logic               w_ovf_clr;
    logic [7:0]         w_head;
    logic               w_unused_d;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_done       = w_empty && (r_state == S_IDLE);
    assign w_bit_end    = (r_baud == BAUD_LAST);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_bitpos_inc = r_bitpos + 3'd1;

    assign w_push_req   = we && (a == 3'd0);
    assign w_ctrl_wr    = we && (a == 3'd1);
    assign w_flush      = w_ctrl_wr && d[25];
    assign w_ovf_clr    = w_ctrl_wr && d[24];
    // Full check uses the pre-edge count, so a simultaneous pop never admits the push.
    assign w_push       = w_push_req && !w_full && !w_flush;
    assign w_unused_d   = ^d[23:0];

    assign tx  = r_tx;
    assign irq = r_irq;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, line level, bit position, baud restart and FIFO pop
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud + 1'b1;
        w_tx_nxt     = r_tx;
        w_bitpos_nxt = r_bitpos;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt   = '0;
                    w_tx_nxt     = r_shift[0];
                    w_bitpos_nxt = '0;
                    w_state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bitpos == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bitpos_nxt = w_bitpos_inc;
                        w_tx_nxt     = r_shift[w_bitpos_inc];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_nxt  = '0;
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transmit datapath: baud counter, line register, bit index, shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud   <= '0;
            r_tx     <= 1'b1;
            r_bitpos <= '0;
            r_shift  <= '0;
        end else begin
            r_baud   <= w_baud_nxt;
            r_tx     <= w_tx_nxt;
            r_bitpos <= w_bitpos_nxt;
            if (w_pop) r_shift <= w_head;
        end
    end

    // FIFO storage (no reset needed; validity tracked by pointers/count)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= d[31:24];
    end

    // FIFO pointers and count; flush overrides push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Control/status registers: sticky overflow, irq enable, registered irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ovf_clr)
                r_ovf <= 1'b0;
            else if (w_push_req && w_full && !w_flush)
                r_ovf <= 1'b1;
            if (we && (a == 3'd3))
                r_irq_en <= d[24];
            r_irq <= r_irq_en && w_done;
        end
    end

    // Combinational register readback on the top byte lane
    always_comb begin
        spo = '0;
        case (a)
            3'd1: begin
                spo[24] = w_done;
                spo[25] = w_full;
                spo[26] = r_ovf;
            end
            3'd2:    spo[24+FIFO_AW:24] = r_count;
            3'd3:    spo[24] = r_irq_en;
            default: spo = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the transmitter.
module tb_uart_tx_fifo;

    localparam int DIV   = 10;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        irq;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_irq_en;
    logic       m_irq;
    logic       m_active;
    logic [7:0] m_cur;
    int         m_fstart;
    int         m_cyc = 0;

    uart_tx_fifo #(
        .CLOCK_FREQ(1000000),
        .BAUD_RATE (100000),
        .FIFO_AW   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .d  (d),
        .we (we),
        .spo(spo),
        .irq(irq),
        .tx (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, m_cyc);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_irq    = 1'b0;
        m_active = 1'b0;
    endfunction

    // Line level as a function of time elapsed since the start bit began
    function automatic logic model_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (m_cyc - m_fstart) / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    function automatic void model_edge(input logic w, input logic [2:0] addr, input logic [31:0] data);
        logic irq_nxt;
        logic full_pre;
        m_cyc++;
        irq_nxt  = m_irq_en && (m_q.size() == 0) && !m_active;
        full_pre = (m_q.size() == DEPTH);
        if (m_active && (m_cyc - m_fstart == 10 * DIV)) m_active = 1'b0;
        if (!m_active && m_q.size() > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_fstart = m_cyc;
        end
        if (w && addr == 3'd0) begin
            if (full_pre) m_ovf = 1'b1;
            else          m_q.push_back(data[31:24]);
        end
        if (w && addr == 3'd1) begin
            if (data[24]) m_ovf = 1'b0;
            if (data[25]) m_q.delete();
        end
        if (w && addr == 3'd3) m_irq_en = data[24];
        m_irq = irq_nxt;
    endfunction

    task automatic check_all();
        logic [31:0] e;
        we = 1'b0;
        chk("tx",  {31'd0, tx},  {31'd0, model_tx()});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        a = 3'd0; #1;
        chk("rd_a0", spo, 32'd0);
        a = 3'd1; #1;
        e = '0;
        e[24] = (m_q.size() == 0) && !m_active;
        e[25] = (m_q.size() == DEPTH);
        e[26] = m_ovf;
        chk("status", spo, e);
        a = 3'd2; #1;
        e = 32'(m_q.size()) << 24;
        chk("count", spo, e);
        a = 3'd3; #1;
        e = '0;
        e[24] = m_irq_en;
        chk("irq_en", spo, e);
    endtask

    task automatic tick(input logic w, input logic [2:0] addr, input logic [31:0] data);
        we = w;
        a  = addr;
        d  = data;
        @(posedge clk);
        model_edge(w, addr, data);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic push(input logic [7:0] b);
        tick(1'b1, 3'd0, {b, 24'($urandom)});
    endtask

    initial begin
        rst = 1'b1;
        we  = 1'b0;
        a   = 3'd0;
        d   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single frame of 0x55
        push(8'h55);
        idle(110);

        // Three back-to-back frames
        push(8'h41);
        push(8'h42);
        push(8'h43);
        idle(310);

        // Overflow with a frame in flight, then clear it
        push(8'h10);
        idle(3);
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        chk("ovf_count16", 32'(m_q.size()), 32'd16);
        tick(1'b1, 3'd1, 32'h0100_0000);
        push(8'hEE);
        tick(1'b1, 3'd1, 32'h0300_0000);
        idle(120);

        // Drained interrupt
        tick(1'b1, 3'd3, 32'h0100_0000);
        idle(3);
        push(8'hA5);
        idle(110);
        tick(1'b1, 3'd3, 32'h0000_0000);
        idle(3);

        // Flush during the first of five frames
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        idle(20);
        tick(1'b1, 3'd1, 32'h0200_0000);
        idle(120);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      idle(1);
            else if (r < 88) push(8'($urandom));
            else if (r < 92) tick(1'b1, 3'd1, {6'($urandom), 2'($urandom), 24'($urandom)});
            else if (r < 95) tick(1'b1, 3'd3, {7'($urandom), 1'($urandom), 24'($urandom)});
            else             tick(1'b1, 3'($urandom_range(4, 7)) & 3'b110 | 3'($urandom_range(0, 1)), $urandom);
        end
        idle(10);

        // Asynchronous reset in the middle of the data bits
        tick(1'b1, 3'd3, 32'h0100_0000);
        push(8'h3C);
        idle(35);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        push(8'h96);
        idle(110);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
